// File: rtl/scsp_dma_ctrl_pkg.sv
// Shared types and constants for the SCSP DMA sequencer.
package scsp_dma_ctrl_pkg;

  localparam int unsigned DMA_MEM_AW = 19;
  localparam int unsigned DMA_REG_AW = 11;
  localparam int unsigned DMA_LEN_W  = 11;
  localparam int unsigned DMA_DATA_W = 16;

  typedef enum logic [1:0] {
    DST_IDLE  = 2'd0,
    DST_READ  = 2'd1,
    DST_WRITE = 2'd2,
    DST_DONE  = 2'd3
  } DMAState_t;

  localparam logic DMA_DIR_MEM2REG = 1'b0;
  localparam logic DMA_DIR_REG2MEM = 1'b1;

  // True when the transfer reads sound RAM and writes the register area
  function automatic logic src_is_mem(input logic dir);
    return dir == DMA_DIR_MEM2REG;
  endfunction

endpackage

// File: rtl/scsp_dma_ctrl_cnt.sv
// Address and length counters for the SCSP DMA sequencer.
// Both address counters wrap independently at their own width.
module scsp_dma_cnt #(
  parameter int unsigned MEM_AW = 19,
  parameter int unsigned REG_AW = 11,
  parameter int unsigned LEN_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [MEM_AW-1:0] mea,
  input  logic [REG_AW-1:0] rga,
  input  logic [LEN_W-1:0]  tlg,
  output logic [MEM_AW-1:0] mem_a,
  output logic [REG_AW-1:0] reg_a,
  output logic              last_c
);

  logic [LEN_W-1:0] cnt;

  // Load on start, advance both addresses and consume one word per write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_a <= '0;
      reg_a <= '0;
      cnt   <= '0;
    end else if (load) begin
      mem_a <= mea;
      reg_a <= rga;
      cnt   <= tlg;
    end else if (step) begin
      mem_a <= mem_a + MEM_AW'(1);
      reg_a <= reg_a + REG_AW'(1);
      cnt   <= cnt - LEN_W'(1);
    end
  end

  assign last_c = (cnt == LEN_W'(1));

endmodule

// File: rtl/scsp_dma_ctrl.sv
// SCSP DMA sequencer: moves 16-bit words between sound RAM and the
// internal register area. Optional macro SCSP_DMA_ABORT_EN adds the
// DEXE_CLR abort input, honoured at the next word boundary.
module scsp_dma_ctrl
  import scsp_dma_ctrl_pkg::*;
#(
  parameter int unsigned MEM_AW = DMA_MEM_AW,
  parameter int unsigned REG_AW = DMA_REG_AW
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [MEM_AW-1:0]     DMEA,
  input  logic [REG_AW-1:0]     DRGA,
  input  logic [DMA_LEN_W-1:0]  DTLG,
  input  logic                  DDIR,
  input  logic                  DGATE,
  input  logic                  DEXE_SET,
`ifdef SCSP_DMA_ABORT_EN
  input  logic                  DEXE_CLR,
`endif
  output logic                  DEXE,
  output logic                  DMA_END,
  output logic                  MEM_REQ,
  output logic                  MEM_WE,
  output logic [MEM_AW-1:0]     MEM_A,
  output logic [DMA_DATA_W-1:0] MEM_DO,
  input  logic [DMA_DATA_W-1:0] MEM_DI,
  input  logic                  MEM_ACK,
  output logic                  REG_REQ,
  output logic                  REG_WE,
  output logic [REG_AW-1:0]     REG_A,
  output logic [DMA_DATA_W-1:0] REG_DO,
  input  logic [DMA_DATA_W-1:0] REG_DI,
  input  logic                  REG_ACK
);

  DMAState_t             state;
  logic                  dir_q;
  logic                  gate_q;
  logic [DMA_DATA_W-1:0] buf_q;
  logic                  cnt_load;
  logic                  cnt_step;
  logic                  cnt_last;
  logic                  src_ack;
  logic                  dst_ack;
  logic                  abort_c;

  // Only an ACK on the port currently being requested counts
  assign src_ack = src_is_mem(dir_q) ? (MEM_ACK & MEM_REQ) : (REG_ACK & REG_REQ);
  assign dst_ack = src_is_mem(dir_q) ? (REG_ACK & REG_REQ) : (MEM_ACK & MEM_REQ);

  assign cnt_load = (state == DST_IDLE) && DEXE_SET;
  assign cnt_step = (state == DST_WRITE) && dst_ack;

  assign MEM_DO = buf_q;
  assign REG_DO = buf_q;

  scsp_dma_cnt #(
    .MEM_AW (MEM_AW),
    .REG_AW (REG_AW),
    .LEN_W  (DMA_LEN_W)
  ) u_cnt (
    .clk    (CLK),
    .rst_n  (RST_N),
    .load   (cnt_load),
    .step   (cnt_step),
    .mea    (DMEA),
    .rga    (DRGA),
    .tlg    (DTLG),
    .mem_a  (MEM_A),
    .reg_a  (REG_A),
    .last_c (cnt_last)
  );

`ifdef SCSP_DMA_ABORT_EN
  logic abort_q;

  // Hold a CPU abort request until the in-flight word's write is acknowledged
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      abort_q <= 1'b0;
    end else if (state == DST_READ || state == DST_WRITE) begin
      if (DEXE_CLR) abort_q <= 1'b1;
    end else begin
      abort_q <= 1'b0;
    end
  end

  assign abort_c = abort_q | DEXE_CLR;
`else
  assign abort_c = 1'b0;
`endif

  // Sequencer: state, latched config, data buffer and registered bus strobes
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= DST_IDLE;
      dir_q   <= 1'b0;
      gate_q  <= 1'b0;
      buf_q   <= '0;
      DEXE    <= 1'b0;
      DMA_END <= 1'b0;
      MEM_REQ <= 1'b0;
      MEM_WE  <= 1'b0;
      REG_REQ <= 1'b0;
      REG_WE  <= 1'b0;
    end else begin
      DMA_END <= 1'b0;
      case (state)
        DST_IDLE: begin
          if (DEXE_SET) begin
            dir_q  <= DDIR;
            gate_q <= DGATE;
            buf_q  <= '0;
            DEXE   <= 1'b1;
            if (DTLG == '0) begin
              state <= DST_DONE;
            end else if (DGATE) begin
              state   <= DST_WRITE;
              MEM_REQ <= ~src_is_mem(DDIR);
              MEM_WE  <= ~src_is_mem(DDIR);
              REG_REQ <= src_is_mem(DDIR);
              REG_WE  <= src_is_mem(DDIR);
            end else begin
              state   <= DST_READ;
              MEM_REQ <= src_is_mem(DDIR);
              MEM_WE  <= 1'b0;
              REG_REQ <= ~src_is_mem(DDIR);
              REG_WE  <= 1'b0;
            end
          end
        end
        DST_READ: begin
          if (src_ack) begin
            buf_q   <= src_is_mem(dir_q) ? MEM_DI : REG_DI;
            state   <= DST_WRITE;
            MEM_REQ <= ~src_is_mem(dir_q);
            MEM_WE  <= ~src_is_mem(dir_q);
            REG_REQ <= src_is_mem(dir_q);
            REG_WE  <= src_is_mem(dir_q);
          end
        end
        DST_WRITE: begin
          // Gated transfers keep the destination request up between words
          if (dst_ack) begin
            if (cnt_last || abort_c) begin
              state   <= DST_DONE;
              MEM_REQ <= 1'b0;
              MEM_WE  <= 1'b0;
              REG_REQ <= 1'b0;
              REG_WE  <= 1'b0;
            end else if (!gate_q) begin
              state   <= DST_READ;
              MEM_REQ <= src_is_mem(dir_q);
              MEM_WE  <= 1'b0;
              REG_REQ <= ~src_is_mem(dir_q);
              REG_WE  <= 1'b0;
            end
          end
        end
        DST_DONE: begin
          DMA_END <= 1'b1;
          DEXE    <= 1'b0;
          state   <= DST_IDLE;
        end
        default: state <= DST_IDLE;
      endcase
    end
  end

endmodule
